se_stream_out: RTL and testbench
================================

Name: se_stream_out

Overview:
- Consumer at the output end of the sorting engine.
- Captures one sorted parallel array when the engine's valid_out rises.
- Streams the captured array one element per beat, index 0 (largest) first, over a valid/ready handshake.
- Sits between the sorting engine and any narrow downstream sink: serializer, FIFO or checker.

Parameters:
- DATAWIDTH, 8, bits per element (matches the engine).
- ARRAYLENGTH, 10, elements per array (matches the engine); must be >= 2.
- IDXW, derived as clog2(ARRAYLENGTH) with a minimum of 1, width of the element index.

Ports:
- clk  in  1  system clock; all state is updated on its rising edge.
- rst_n  in  1  reset; one clock; reset is asynchronous and active-low.
- arr_valid  in  1  the engine's valid_out; may stay high for more than one cycle.
- arr_data  in  DATAWIDTH*ARRAYLENGTH  the engine's array_out; element i occupies bits [(i+1)*DATAWIDTH-1 : i*DATAWIDTH].
- out_valid  out  1  the current element is presented.
- out_ready  in  1  the sink accepts the element.
- out_data  out  DATAWIDTH  current element.
- out_index  out  IDXW  index of the current element.
- out_last  out  1  the current element is index ARRAYLENGTH-1.
- busy  out  1  an array is held and not yet fully drained.
- overrun  out  1  one-cycle pulse when an array is dropped.
- order_err  out  1  sticky ordering violation flag (see Optional Feature).

Behaviour:
- Reset values: state IDLE; out_valid, out_last, busy, overrun and order_err are 0; out_index is 0; out_data is 0; buffer cleared; edge register 0.
- Capture trigger (cap) is the rising edge of arr_valid: arr_valid high and the previous-cycle registered arr_valid low. A held-high arr_valid captures exactly once.
- States are IDLE and STREAM.
- IDLE:
  - On cap, register arr_data into the buffer, set idx to 0 and go to STREAM.
  - The first beat is presented in the next cycle. Latency from the arr_valid edge to out_valid is 1 cycle.
- STREAM:
  - out_valid is 1, out_data is buffer[idx], out_index is idx, out_last is (idx == ARRAYLENGTH-1), busy is 1.
  - A beat completes when out_valid and out_ready are both high. On a completed beat, idx increments.
  - When the last beat completes, go to IDLE, or reload and stay in STREAM if cap occurs that same cycle.
- Back-to-back arrays: cap coincident with the last beat completing is accepted. There is no bubble: the next cycle presents index 0 of the new array.
- Overrun: cap in STREAM other than on the last completing beat drops the new array.
  - overrun pulses high for 1 cycle.
  - The buffer and idx are untouched.
- Stall: while out_ready is 0, out_data, out_index and out_last hold stable and out_valid stays 1. out_valid is never withdrawn without a completed beat.
- Full throughput: one element per cycle with out_ready held high. A full array drains in ARRAYLENGTH cycles.
- Asynchronous reset mid-stream aborts the array immediately: outputs go to reset values and the buffer contents are discarded.
- Arithmetic: idx is an unsigned IDXW counter. It never wraps past ARRAYLENGTH-1; it returns to 0 only on capture.

Optional Feature:
- Macro: SE_STREAM_ORDER_CHECK_EN.
- Defined:
  - The block compares each completed beat's element with the previous completed beat of the same array, unsigned.
  - If the current element is greater than the previous one, order_err is set one cycle after that beat and stays high (sticky).
  - order_err clears on the next capture.
  - Index 0 is never flagged.
- Not defined: order_err is tied to 0, and no comparator or previous-element register is built.

Decomposition:
- Shared package se_pkg holds:
  - state encoding localparams ST_IDLE and ST_STREAM;
  - the clog2 index-width helper;
  - default DATAWIDTH and ARRAYLENGTH constants, shared with the engine.
- One natural sub-module, se_order_check: previous-element register, comparator and sticky flag.
  - It is instantiated only under SE_STREAM_ORDER_CHECK_EN.
- Everything else stays in se_stream_out.

Test Plan (DATAWIDTH=8, ARRAYLENGTH=10):
- Basic drain: hold arr_valid for 2 cycles with array {90,80,...,0} (index 0 = 90) and out_ready=1.
  - One capture only.
  - 10 beats, 90 down to 0, out_index 0..9, out_last only on index 9.
  - busy falls after the last beat; overrun stays 0.
- Backpressure: toggle out_ready every other cycle on the same array.
  - out_data and out_index hold while out_ready is low.
  - Beats arrive in order; 10 beats total.
- Back-to-back: raise arr_valid with array B exactly on the cycle index 9 of array A completes.
  - The cycle after A's last beat presents B index 0, with no gap.
  - overrun stays 0.
- Overrun: raise arr_valid with array C while array A is at index 4.
  - overrun pulses for 1 cycle.
  - A finishes intact (indices 4..9); C is never emitted.
- Reset mid-stream: drive rst_n low asynchronously at index 3.
  - All outputs go to 0 immediately.
  - After release, a new array streams from index 0.
- Order check with the macro defined: stream {50,40,60,10,...}.
  - order_err goes high 1 cycle after the index-2 beat (60 > 40) and stays high.
  - It clears on the next capture.
  - Without the macro, order_err stays 0.

Source files
------------

// File: rtl/se_pkg.sv
// se_pkg: shared constants, FSM state encoding and index-width helper for the sorting engine.
package se_pkg;

   localparam int SE_DATAWIDTH   = 8;
   localparam int SE_ARRAYLENGTH = 10;

   localparam logic ST_IDLE   = 1'b0;
   localparam logic ST_STREAM = 1'b1;

   // Index width for n elements, never narrower than one bit.
   function automatic int se_idx_w(input int n);
      return (n <= 2) ? 1 : $clog2(n);
   endfunction

endpackage

// File: rtl/se_order_check.sv
// se_order_check: sticky flag raised when a completed beat exceeds the previous beat of the same array.
module se_order_check #(
   parameter int DATAWIDTH = 8
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 clr,
   input  logic                 beat,
   input  logic                 first,
   input  logic [DATAWIDTH-1:0] data,
   output logic                 err
);

   logic [DATAWIDTH-1:0] prev_q, prev_d;
   logic                 err_q, err_d;
   logic                 viol;

   // A violation on the very beat that coincides with a new capture still gets reported.
   always_comb begin
      viol   = beat && !first && (data > prev_q);
      prev_d = beat ? data : prev_q;
      err_d  = (clr ? 1'b0 : err_q) | viol;
   end

   // Previous-element and flag registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         prev_q <= '0;
         err_q  <= 1'b0;
      end else begin
         prev_q <= prev_d;
         err_q  <= err_d;
      end
   end

   assign err = err_q;

endmodule

// File: rtl/se_stream_out.sv
// se_stream_out: captures a sorted array on the rising edge of arr_valid and streams it one element per beat.
// Optional ordering check enabled by defining SE_STREAM_ORDER_CHECK_EN.
module se_stream_out
   import se_pkg::*;
#(
   parameter int DATAWIDTH   = SE_DATAWIDTH,
   parameter int ARRAYLENGTH = SE_ARRAYLENGTH,
   parameter int IDXW        = se_idx_w(ARRAYLENGTH)
) (
   input  logic                             clk,
   input  logic                             rst_n,
   input  logic                             arr_valid,
   input  logic [DATAWIDTH*ARRAYLENGTH-1:0] arr_data,
   output logic                             out_valid,
   input  logic                             out_ready,
   output logic [DATAWIDTH-1:0]             out_data,
   output logic [IDXW-1:0]                  out_index,
   output logic                             out_last,
   output logic                             busy,
   output logic                             overrun,
   output logic                             order_err
);

   localparam logic [IDXW-1:0] LAST_IDX = IDXW'(ARRAYLENGTH - 1);

   logic                                 state_q, state_d;
   logic [IDXW-1:0]                      idx_q, idx_d;
   logic [ARRAYLENGTH-1:0][DATAWIDTH-1:0] buf_q, buf_d;
   logic                                 vld_q;
   logic                                 overrun_q, overrun_d;
   logic                                 cap, beat, last_beat, load;

   // State, buffer, index, edge detector and overrun pulse registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= ST_IDLE;
         idx_q     <= '0;
         buf_q     <= '0;
         vld_q     <= 1'b0;
         overrun_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         idx_q     <= idx_d;
         buf_q     <= buf_d;
         vld_q     <= arr_valid;
         overrun_q <= overrun_d;
      end
   end

   // Next state: a capture is accepted when idle or exactly on the final beat, otherwise it is dropped.
   always_comb begin
      cap       = arr_valid && !vld_q;
      beat      = (state_q == ST_STREAM) && out_ready;
      last_beat = beat && (idx_q == LAST_IDX);
      load      = cap && ((state_q == ST_IDLE) || last_beat);
      state_d   = load ? ST_STREAM : (last_beat ? ST_IDLE : state_q);
      buf_d     = load ? arr_data : buf_q;
      idx_d     = load ? '0 : ((beat && !last_beat) ? idx_q + 1'b1 : idx_q);
      overrun_d = cap && !load;
   end

   // Outputs are zeroed while idle so the stale index left by the last beat never shows.
   always_comb begin
      out_valid = (state_q == ST_STREAM);
      busy      = out_valid;
      out_data  = out_valid ? buf_q[idx_q] : '0;
      out_index = out_valid ? idx_q : '0;
      out_last  = out_valid && (idx_q == LAST_IDX);
      overrun   = overrun_q;
   end

`ifdef SE_STREAM_ORDER_CHECK_EN
   se_order_check #(
      .DATAWIDTH(DATAWIDTH)
   ) u_order_check (
      .clk   (clk),
      .rst_n (rst_n),
      .clr   (load),
      .beat  (beat),
      .first (idx_q == '0),
      .data  (out_data),
      .err   (order_err)
   );
`else
   assign order_err = 1'b0;
`endif

endmodule

// File: tb/tb_se_stream_out.sv
// tb_se_stream_out: vector table, directed corner sequences and randomized traffic against a queue-level model.
module tb_se_stream_out;

   localparam int DW = 8;
   localparam int AL = 10;
`ifdef SE_STREAM_ORDER_CHECK_EN
   localparam int ORD_EN = 1;
`else
   localparam int ORD_EN = 0;
`endif

   logic            clk = 1'b0;
   logic            rst_n = 1'b0;
   logic            arr_valid = 1'b0;
   logic [DW*AL-1:0] arr_data = '0;
   logic            out_ready = 1'b0;
   logic            out_valid, out_last, busy, overrun, order_err;
   logic [DW-1:0]   out_data;
   logic [3:0]      out_index;

   int n_checks = 0;
   int n_pass   = 0;

   // Model: the held array as a list, the position of the presented element and a few flags.
   int m_arr[AL];
   int m_pos;
   bit m_busy, m_pav, m_over, m_err;
   int m_prev;

   se_stream_out #(.DATAWIDTH(DW), .ARRAYLENGTH(AL)) dut (
      .clk(clk), .rst_n(rst_n), .arr_valid(arr_valid), .arr_data(arr_data),
      .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
      .out_index(out_index), .out_last(out_last), .busy(busy),
      .overrun(overrun), .order_err(order_err)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input int act, input int exp);
      n_checks++;
      if (act == exp) n_pass++;
      else $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
   endtask

   function automatic logic [DW*AL-1:0] pack(input int v[AL]);
      logic [DW*AL-1:0] r = '0;
      for (int i = 0; i < AL; i++) r[i*DW +: DW] = DW'(v[i]);
      return r;
   endfunction

   task automatic model_reset();
      m_busy = 0; m_pav = 0; m_over = 0; m_err = 0; m_pos = 0; m_prev = 0;
   endtask

   task automatic check_model();
      chk("valid", int'(out_valid), int'(m_busy));
      chk("busy", int'(busy), int'(m_busy));
      chk("data", int'(out_data), m_busy ? m_arr[m_pos] : 0);
      chk("index", int'(out_index), m_busy ? m_pos : 0);
      chk("last", int'(out_last), int'(m_busy && m_pos == AL - 1));
      chk("overrun", int'(overrun), int'(m_over));
      chk("order_err", int'(order_err), ORD_EN ? int'(m_err) : 0);
   endtask

   // One clock: apply inputs, advance the model by the handshake rules, compare after the edge.
   task automatic cycle(input bit av, input logic [DW*AL-1:0] d, input bit rdy);
      bit cap, beat, fin, viol;
      arr_valid = av; arr_data = d; out_ready = rdy;
      cap  = av && !m_pav;
      beat = m_busy && rdy;
      fin  = beat && m_pos == AL - 1;
      viol = beat && m_pos != 0 && m_arr[m_pos] > m_prev;
      if (beat) m_prev = m_arr[m_pos];
      m_over = cap && m_busy && !fin;
      if (cap && (!m_busy || fin)) begin
         for (int i = 0; i < AL; i++) m_arr[i] = int'(d[i*DW +: DW]);
         m_pos = 0; m_busy = 1; m_err = 0;
      end else if (beat) begin
         if (fin) m_busy = 0;
         else m_pos++;
      end
      if (viol) m_err = 1;
      m_pav = av;
      @(posedge clk); #1;
      check_model();
   endtask

   typedef struct {
      bit av;
      bit rdy;
      bit ev;
      int edat;
      int eidx;
      bit elast;
   } vec_t;

   vec_t vt[AL + 2];
   int   va[AL], vb[AL], vc[AL], vo[AL];
   logic [DW*AL-1:0] a_d, b_d, c_d, o_d, r_d;
   int   held_data, held_idx;

   initial begin
      for (int i = 0; i < AL; i++) begin
         va[i] = 90 - 10 * i;
         vb[i] = 200 - i;
         vc[i] = 33;
         vo[i] = 0;
      end
      vo[0] = 50; vo[1] = 40; vo[2] = 60; vo[3] = 10;
      a_d = pack(va); b_d = pack(vb); c_d = pack(vc); o_d = pack(vo);
      // Basic drain table: arr_valid held two cycles, ready always high.
      for (int k = 0; k < AL + 2; k++) begin
         vt[k].av    = (k < 2);
         vt[k].rdy   = 1'b1;
         vt[k].ev    = (k < AL);
         vt[k].edat  = (k < AL) ? 90 - 10 * k : 0;
         vt[k].eidx  = (k < AL) ? k : 0;
         vt[k].elast = (k == AL - 1);
      end

      model_reset();
      repeat (2) @(posedge clk);
      #1;
      check_model();
      chk("reset_index", int'(out_index), 0);
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk); #1;

      for (int k = 0; k < AL + 2; k++) begin
         cycle(vt[k].av, a_d, vt[k].rdy);
         chk("tbl_valid", int'(out_valid), int'(vt[k].ev));
         chk("tbl_data", int'(out_data), vt[k].edat);
         chk("tbl_index", int'(out_index), vt[k].eidx);
         chk("tbl_last", int'(out_last), int'(vt[k].elast));
         chk("tbl_overrun", int'(overrun), 0);
      end

      // Backpressure: ready low on alternate cycles, presented beat must hold.
      cycle(1, a_d, 0);
      for (int k = 0; k < 2 * AL; k++) begin
         held_data = int'(out_data); held_idx = int'(out_index);
         cycle(0, a_d, k[0]);
         if (!k[0]) begin
            chk("bp_hold_data", int'(out_data), held_data);
            chk("bp_hold_index", int'(out_index), held_idx);
         end
      end
      cycle(0, a_d, 1);
      chk("bp_done", int'(busy), 0);

      // Back-to-back: B captured on the cycle A's index 9 completes.
      cycle(1, a_d, 1);
      repeat (AL - 1) cycle(0, a_d, 1);
      chk("b2b_at_last", int'(out_index), AL - 1);
      cycle(1, b_d, 1);
      chk("b2b_valid", int'(out_valid), 1);
      chk("b2b_data", int'(out_data), 200);
      chk("b2b_index", int'(out_index), 0);
      chk("b2b_overrun", int'(overrun), 0);
      repeat (AL) cycle(0, b_d, 1);

      // Overrun: C arrives while A presents index 4.
      cycle(1, a_d, 1);
      repeat (4) cycle(0, a_d, 1);
      chk("ovr_at4", int'(out_index), 4);
      cycle(1, c_d, 1);
      chk("ovr_pulse", int'(overrun), 1);
      chk("ovr_a_kept", int'(out_data), 40);
      cycle(0, c_d, 1);
      chk("ovr_pulse_end", int'(overrun), 0);
      repeat (AL) cycle(0, c_d, 1);

      // Asynchronous reset while index 3 is presented.
      cycle(1, b_d, 1);
      repeat (3) cycle(0, b_d, 1);
      chk("rst_at3", int'(out_index), 3);
      #2 rst_n = 1'b0;
      #1;
      model_reset();
      check_model();
      @(negedge clk);
      rst_n = 1'b1;
      cycle(1, a_d, 1);
      chk("rst_restart_data", int'(out_data), 90);
      repeat (AL) cycle(0, a_d, 1);

      // Ordering: 60 after 40 flags one cycle after the index-2 beat, clears on next capture.
      cycle(1, o_d, 1);
      cycle(0, o_d, 1);
      cycle(0, o_d, 1);
      chk("ord_before", int'(order_err), 0);
      cycle(0, o_d, 1);
      chk("ord_set", int'(order_err), ORD_EN);
      repeat (AL) cycle(0, o_d, 1);
      chk("ord_sticky", int'(order_err), ORD_EN);
      cycle(1, a_d, 1);
      chk("ord_clear", int'(order_err), 0);
      repeat (AL) cycle(0, a_d, 1);

      // Randomized traffic.
      for (int n = 0; n < 600; n++) begin
         for (int i = 0; i < AL; i++) r_d[i*DW +: DW] = DW'($urandom_range(0, 255));
         cycle($urandom_range(0, 5) == 0, r_d, $urandom_range(0, 3) != 0);
      end

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
